// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC bus fabric: FSM states, error read data
// and the default two-slave address map.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam int          MAX_SLAVES = 8;
  localparam logic [31:0] ERR_RDATA  = 32'h0000_0000;

  // Slave 0 is memory at 0x0000_0xxx, slave 1 is the LED block at 0x8000_000x.
  localparam logic [63:0] DEF_SLAVE_BASE = {32'h8000_0000, 32'h0000_0000};
  localparam logic [63:0] DEF_SLAVE_MASK = {32'hFFFF_FFF0, 32'hFFFF_F000};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/soc_bus_fabric_if.sv
// Core-side and slave-side bus signals of the fabric. The slave modport is the
// fabric's own view; the master modport is the view of the surrounding SoC.
interface soc_bus_fabric_if #(
  parameter int NUM_SLAVES = 2
);
  logic                       proc_rd_en_i;
  logic                       proc_wr_en_i;
  logic [31:0]                proc_addr_i;
  logic [31:0]                proc_data_i;
  logic [31:0]                proc_data_o;
  logic                       proc_ack_o;
  logic                       proc_err_o;
  logic [NUM_SLAVES-1:0]      slv_rd_en_o;
  logic [NUM_SLAVES-1:0]      slv_wr_en_o;
  logic [31:0]                slv_addr_o;
  logic [31:0]                slv_data_o;
  logic [NUM_SLAVES*32-1:0]   slv_data_i;
  logic [NUM_SLAVES-1:0]      slv_ack_i;

  modport master (
    output proc_rd_en_i, proc_wr_en_i, proc_addr_i, proc_data_i, slv_data_i, slv_ack_i,
    input  proc_data_o, proc_ack_o, proc_err_o, slv_rd_en_o, slv_wr_en_o, slv_addr_o,
           slv_data_o
  );

  modport slave (
    input  proc_rd_en_i, proc_wr_en_i, proc_addr_i, proc_data_i, slv_data_i, slv_ack_i,
    output proc_data_o, proc_ack_o, proc_err_o, slv_rd_en_o, slv_wr_en_o, slv_addr_o,
           slv_data_o
  );
endinterface

// File: rtl/soc_bus_decoder.sv
// Combinational address decoder: lowest-index slave whose (addr & mask) == base wins.
module soc_bus_decoder
  import soc_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int                       IDX_W      = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the top index down so the lowest matching slave is written last.
  always_comb begin
    o_hit = 1'b0;
    o_idx = {IDX_W{1'b0}};
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end else begin
        o_hit = o_hit;
      end
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-master, N-slave bus fabric with registered strobes, read data and ack.
// Define SOC_BUS_FABRIC_TIMEOUT_EN to terminate hung slave accesses with an error.
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = DEF_SLAVE_BASE,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = DEF_SLAVE_MASK,
  parameter int                       TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  soc_bus_fabric_if.slave  bus
);

  localparam int IDX_W = idx_width(NUM_SLAVES);

  bus_state_e              r_state;
  bus_state_e              w_state_nxt;
  logic [31:0]             r_addr;
  logic [31:0]             r_wdata;
  logic                    r_is_rd;
  logic [IDX_W-1:0]        r_idx;
  logic                    w_hit;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_req;
  logic                    w_bad_req;
  logic                    w_sel_ack;
  logic [31:0]             w_sel_data;
  logic                    w_tmo_hit;
  logic [NUM_SLAVES-1:0]   r_rd_en;
  logic [NUM_SLAVES-1:0]   r_wr_en;
  logic                    r_ack;
  logic                    r_err;
  logic [31:0]             r_rdata;
  logic [NUM_SLAVES-1:0]   w_rd_en_nxt;
  logic [NUM_SLAVES-1:0]   w_wr_en_nxt;
  logic                    w_ack_nxt;
  logic                    w_err_nxt;
  logic [31:0]             w_rdata_nxt;
  logic [IDX_W-1:0]        w_cur_idx;
  logic                    w_cur_rd;

  soc_bus_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .i_addr (bus.proc_addr_i),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  assign w_req      = bus.proc_rd_en_i | bus.proc_wr_en_i;
  assign w_bad_req  = (bus.proc_rd_en_i & bus.proc_wr_en_i) | ~w_hit;
  assign w_sel_ack  = bus.slv_ack_i[r_idx];
  assign w_sel_data = bus.slv_data_i[32*int'(r_idx) +: 32];

`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_tmo_cnt;

  // Counts ACCESS cycles; held at zero everywhere else so each access starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else if (r_state != ST_ACCESS) begin
      r_tmo_cnt <= {CNT_W{1'b0}};
    end else begin
      r_tmo_cnt <= r_tmo_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_tmo_hit = (r_state == ST_ACCESS) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a selected ack beats a simultaneous timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_bad_req) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (w_sel_ack || w_tmo_hit) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered.
  always_comb begin
    w_cur_idx   = (r_state == ST_IDLE) ? w_idx : r_idx;
    w_cur_rd    = (r_state == ST_IDLE) ? bus.proc_rd_en_i : r_is_rd;
    w_rd_en_nxt = {NUM_SLAVES{1'b0}};
    w_wr_en_nxt = {NUM_SLAVES{1'b0}};
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = r_rdata;
    case (w_state_nxt)
      ST_ACCESS: begin
        if (w_cur_rd) begin
          w_rd_en_nxt = NUM_SLAVES'(1'b1) << w_cur_idx;
        end else begin
          w_wr_en_nxt = NUM_SLAVES'(1'b1) << w_cur_idx;
        end
      end
      ST_RESP: begin
        w_ack_nxt = 1'b1;
        if ((r_state == ST_ACCESS) && w_sel_ack) begin
          w_err_nxt   = 1'b0;
          w_rdata_nxt = r_is_rd ? w_sel_data : 32'h0000_0000;
        end else begin
          w_err_nxt   = 1'b1;
          w_rdata_nxt = ERR_RDATA;
        end
      end
      default: begin
        w_ack_nxt = 1'b0;
      end
    endcase
  end

  // Transfer context captured when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_is_rd <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
    end else if ((r_state == ST_IDLE) && w_req) begin
      r_addr  <= bus.proc_addr_i;
      r_wdata <= bus.proc_data_i;
      r_is_rd <= bus.proc_rd_en_i;
      r_idx   <= w_idx;
    end else begin
      r_is_rd <= r_is_rd;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_en <= {NUM_SLAVES{1'b0}};
      r_wr_en <= {NUM_SLAVES{1'b0}};
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0000_0000;
    end else begin
      r_rd_en <= w_rd_en_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  assign bus.slv_rd_en_o = r_rd_en;
  assign bus.slv_wr_en_o = r_wr_en;
  assign bus.slv_addr_o  = r_addr;
  assign bus.slv_data_o  = r_wdata;
  assign bus.proc_ack_o  = r_ack;
  assign bus.proc_err_o  = r_err;
  assign bus.proc_data_o = r_rdata;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed bench for soc_bus_fabric: a per-cycle expected timeline built from the
// address map and handshake latency rules, compared against the DUT every cycle.
`timescale 1ns/1ps
module tb_soc_bus_fabric;

  localparam int NS    = 2;
  localparam int TMO   = 16;
  localparam int NEVER = 1000;
  localparam int MAXC  = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  int   req_cyc = 0;
  int   ack_cyc = -1;
  logic ack_err = 1'b0;

  logic [31:0]   m_base [NS] = '{32'h0000_0000, 32'h8000_0000};
  logic [31:0]   m_mask [NS] = '{32'hFFFF_F000, 32'hFFFF_FFF0};

  logic [NS-1:0] e_rd    [MAXC];
  logic [NS-1:0] e_wr    [MAXC];
  logic          e_ack   [MAXC];
  logic          e_err   [MAXC];
  logic [31:0]   e_data  [MAXC];
  logic [31:0]   e_addr  [MAXC];
  logic [31:0]   e_wdata [MAXC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  soc_bus_fabric_if #(.NUM_SLAVES(NS)) bus ();

  soc_bus_fabric #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (64'h8000_0000_0000_0000),
    .SLAVE_MASK     (64'hFFFF_FFF0_FFFF_F000),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return -1;
  endfunction

  task automatic clear_from(input int c);
    for (int i = c; i < MAXC; i++) begin
      e_rd[i] = '0; e_wr[i] = '0; e_ack[i] = 1'b0; e_err[i] = 1'b0;
      e_data[i] = 32'h0; e_addr[i] = 32'h0; e_wdata[i] = 32'h0;
    end
  endtask

  task automatic data_from(input int c, input logic [31:0] v);
    for (int i = c; i < MAXC; i++) e_data[i] = v;
  endtask

  // Every cycle out of reset: the DUT must follow the expected timeline.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n && cyc < MAXC) begin
        chk("proc_ack", {31'd0, bus.proc_ack_o}, {31'd0, e_ack[cyc]});
        chk("proc_err", {31'd0, bus.proc_err_o}, {31'd0, e_err[cyc]});
        chk("proc_data", bus.proc_data_o, e_data[cyc]);
        chk("slv_rd_en", 32'(bus.slv_rd_en_o), 32'(e_rd[cyc]));
        chk("slv_wr_en", 32'(bus.slv_wr_en_o), 32'(e_wr[cyc]));
        if ((e_rd[cyc] | e_wr[cyc]) != '0) begin
          chk("slv_addr", bus.slv_addr_o, e_addr[cyc]);
          chk("slv_wdata", bus.slv_data_o, e_wdata[cyc]);
        end
        if (bus.proc_ack_o) begin
          ack_cyc = cyc;
          ack_err = bus.proc_err_o;
        end
      end
    end
  end

  // One core transfer; the selected slave acks k cycles after the request cycle.
  task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int k, input bit noise);
    int t, s, resp, nstb;
    logic err;
    logic [31:0] d;
    t = cyc; req_cyc = t; ack_cyc = -1;
    s = model_sel(addr);
    if ((rd && wr) || s < 0) begin
      resp = t + 1; err = 1'b1; d = 32'h0;
    end else begin
      nstb = k;
`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
      if (k > TMO) nstb = TMO;
`endif
      resp = t + nstb + 1;
      err  = (nstb != k);
      d    = (rd && !err) ? rdata : 32'h0;
      for (int c = t + 1; c <= t + nstb; c++) begin
        if (rd) e_rd[c] = NS'(1'b1) << s;
        else    e_wr[c] = NS'(1'b1) << s;
        e_addr[c] = addr; e_wdata[c] = wdata;
      end
    end
    e_ack[resp] = 1'b1; e_err[resp] = err;
    data_from(resp, d);
    bus.proc_rd_en_i = rd; bus.proc_wr_en_i = wr;
    bus.proc_addr_i = addr; bus.proc_data_i = wdata;
    for (int j = 0; j < NS; j++) begin
      bus.slv_data_i[j*32 +: 32] = (j == s) ? rdata : 32'hDEAD_BEEF;
      bus.slv_ack_i[j] = noise && (j != s);
    end
    while (cyc <= resp) begin
      @(negedge clk);
      for (int j = 0; j < NS; j++)
        bus.slv_ack_i[j] = ((j == s) && (cyc == t + k)) || (noise && (j != s));
      if (cyc == resp) begin
        bus.proc_rd_en_i = 1'b0; bus.proc_wr_en_i = 1'b0;
      end
    end
  endtask

  initial begin
    bus.proc_rd_en_i = 1'b0; bus.proc_wr_en_i = 1'b0;
    bus.proc_addr_i = 32'h0; bus.proc_data_i = 32'h0;
    bus.slv_data_i = '0; bus.slv_ack_i = '0;
    clear_from(0);
    repeat (3) @(negedge clk);
    chk("reset_ack", {31'd0, bus.proc_ack_o}, 32'd0);
    chk("reset_stb", 32'({bus.slv_rd_en_o, bus.slv_wr_en_o}), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // Model map sanity: hand-derived decode results.
    chk("map_0010", 32'(model_sel(32'h0000_0010)), 32'd0);
    chk("map_8004", 32'(model_sel(32'h8000_0004)), 32'd1);
    chk("map_4000", 32'(model_sel(32'h4000_0000)), 32'hFFFF_FFFF);

    do_xfer(1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 2, 1'b0);
    chk("rd0_latency", 32'(ack_cyc - req_cyc), 32'd3);
    chk("rd0_data", bus.proc_data_o, 32'h1234_5678);
    chk("rd0_err", {31'd0, ack_err}, 32'd0);

    do_xfer(1'b0, 1'b1, 32'h8000_0004, 32'h0000_00A5, 32'h0, 1, 1'b0);
    chk("wr1_latency", 32'(ack_cyc - req_cyc), 32'd2);
    chk("wr1_data", bus.proc_data_o, 32'h0000_0000);

    do_xfer(1'b1, 1'b0, 32'h4000_0000, 32'h0, 32'h5555_AAAA, 1, 1'b0);
    chk("unmapped_latency", 32'(ack_cyc - req_cyc), 32'd1);
    chk("unmapped_err", {31'd0, ack_err}, 32'd1);

    do_xfer(1'b1, 1'b1, 32'h0000_0000, 32'h1, 32'h7777_7777, 1, 1'b0);
    chk("conflict_err", {31'd0, ack_err}, 32'd1);

    do_xfer(1'b1, 1'b0, 32'h8000_000C, 32'h0, 32'h0BAD_F00D, 3, 1'b1);
    chk("rd1_noise_data", bus.proc_data_o, 32'h0BAD_F00D);
    do_xfer(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0000_0FFC, 1, 1'b1);
    do_xfer(1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h1111_1111, 1, 1'b0);
    do_xfer(1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'h2222_2222, 1, 1'b0);
    do_xfer(1'b1, 1'b0, 32'h8000_000F, 32'h0, 32'h3333_3333, 1, 1'b0);
    do_xfer(1'b0, 1'b1, 32'h0000_0100, 32'hFEED_0001, 32'h0, 4, 1'b1);

`ifdef SOC_BUS_FABRIC_TIMEOUT_EN
    do_xfer(1'b1, 1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, TMO, 1'b0);
    chk("tmo_edge_err", {31'd0, ack_err}, 32'd0);
    do_xfer(1'b1, 1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, TMO + 1, 1'b0);
    chk("tmo_late_err", {31'd0, ack_err}, 32'd1);
    do_xfer(1'b0, 1'b1, 32'h8000_0000, 32'h5A, 32'h0, NEVER, 1'b0);
    chk("tmo_hung_latency", 32'(ack_cyc - req_cyc), 32'(TMO + 1));
`else
    do_xfer(1'b1, 1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 40, 1'b0);
    chk("long_wait_latency", 32'(ack_cyc - req_cyc), 32'd41);
    chk("long_wait_err", {31'd0, ack_err}, 32'd0);
`endif

    // Reset in the middle of a held strobe.
    chk_en = 1'b0;
    bus.slv_ack_i = '0;
    bus.proc_rd_en_i = 1'b1; bus.proc_addr_i = 32'h0000_0020;
    repeat (4) @(negedge clk);
    chk("pre_reset_stb", 32'(bus.slv_rd_en_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_stb", 32'({bus.slv_rd_en_o, bus.slv_wr_en_o}), 32'd0);
    chk("async_rst_ack", {31'd0, bus.proc_ack_o}, 32'd0);
    chk("async_rst_data", bus.proc_data_o, 32'd0);
    bus.proc_rd_en_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_from(cyc);
    chk_en = 1'b1;
    @(negedge clk);
    do_xfer(1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h600D_DA7A, 1, 1'b0);
    chk("post_reset_data", bus.proc_data_o, 32'h600D_DA7A);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/soc_bus_fabric.md
# soc_bus_fabric

Parametrised single-master, N-slave bus fabric that sits between the core and all memory-mapped targets (memory, LED and future peripherals) inside the SoC top. It decodes each core access against a per-slave base/mask table, forwards a held strobe to the selected slave until it acknowledges, registers the read data, and returns a one-cycle ack (and error flag) to the core. Unmapped addresses and optionally hung slaves terminate with an error instead of stalling the core.

## Interface
- NUM_SLAVES, 2, number of slave ports (1..8)
- SLAVE_BASE, {32'h8000_0000, 32'h0000_0000}, packed NUM_SLAVES×32 base addresses, slave 0 in bits [31:0]
- SLAVE_MASK, {32'hFFFF_FFF0, 32'hFFFF_F000}, packed NUM_SLAVES×32 masks; hit when (addr & mask) == base
- TIMEOUT_CYCLES, 16, ACCESS cycles without ack before error (≥2)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- proc_rd_en_i  in  1  core read request
- proc_wr_en_i  in  1  core write request
- proc_addr_i  in  32  core byte address
- proc_data_i  in  32  core write data
- proc_data_o  out  32  registered read data to core
- proc_ack_o  out  1  one-cycle transfer completion
- proc_err_o  out  1  valid with proc_ack_o; decode error or timeout
- slv_rd_en_o  out  NUM_SLAVES  per-slave read strobe
- slv_wr_en_o  out  NUM_SLAVES  per-slave write strobe
- slv_addr_o  out  32  latched address, shared
- slv_data_o  out  32  latched write data, shared
- slv_data_i  in  NUM_SLAVES×32  per-slave read data, slave 0 in [31:0]
- slv_ack_i  in  NUM_SLAVES  per-slave completion

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on rd or wr asserted, latch addr, wdata, direction, decoded index. Lowest-index matching slave wins. No match, or rd and wr both high -> RESP with error. Otherwise -> ACCESS.
- ACCESS: drive slv_rd_en_o/slv_wr_en_o bit of selected slave only, held every cycle until ack. Other slaves' strobes 0. slv_ack_i of non-selected slaves ignored.
- On selected ack: capture slv_data_i slice (reads; writes capture 0) -> RESP, err=0.
- RESP: proc_ack_o=1 for exactly one cycle with proc_data_o/proc_err_o valid; strobes 0 -> IDLE.
- Error read data: 32'h0000_0000.
- Core must hold request until ack; requests only sampled in IDLE. Core drops request in the ack cycle; a request still high in IDLE is a new transfer.
- proc_data_o holds last value until next RESP.

## Timing
- Reset (async assert, sync release): state IDLE, all outputs 0, timeout counter 0.
- Reset mid-transfer: strobes and ack drop immediately; transfer discarded.
- Request sampled at edge t: strobe visible cycle t+1; ack in cycle t+k (k≥1) -> proc_ack_o in cycle t+k+1. Minimum 2-cycle latency; back-to-back requests every 3 cycles.
- Decode error: proc_ack_o and proc_err_o high in cycle t+1; no slave strobe ever asserted.
- Timeout counter cleared on ACCESS entry, +1 per ACCESS cycle without ack; at TIMEOUT_CYCLES-1 without ack -> RESP with error. Ack in same cycle as expiry wins (normal completion).
- Late ack after timeout (in RESP/IDLE) ignored.

## Configuration
- SOC_BUS_FABRIC_TIMEOUT_EN defined: timeout counter and timeout error as above.
- Undefined: no counter; ACCESS waits indefinitely; proc_err_o only for decode errors / rd+wr conflict. TIMEOUT_CYCLES ignored.

## Structure
- Package soc_bus_pkg: FSM state enumeration, ERR_RDATA constant, default SLAVE_BASE/SLAVE_MASK map, MAX_SLAVES=8.
- Sub-module soc_bus_decoder: combinational priority decode, outputs hit flag and slave index ($clog2 width, min 1).

## Test plan
- Read 0x0000_0010, slave 0 acks 1 cycle after strobe with 0x1234_5678 -> proc_ack_o 3 cycles after request, proc_data_o=0x1234_5678, err=0, slv_rd_en_o=2'b01 only.
- Write 0x8000_0004 data 0x0000_00A5, slave 1 acks same cycle -> slv_wr_en_o=2'b10 one cycle, slv_data_o=0xA5, proc_ack_o at t+2, err=0.
- Read 0x4000_0000 (unmapped) -> proc_ack_o and proc_err_o at t+1, proc_data_o=0, no strobe.
- With SOC_BUS_FABRIC_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave 1 never acks -> strobe held 16 cycles, then ack+err; ack arriving on 16th cycle instead -> err=0.
- rst_n low while slave 0 strobe held -> strobes 0 asynchronously; after release, IDLE, outputs 0, next read completes normally.
- rd and wr both high at 0x0000_0000 -> error response at t+1, no strobe.
